// File: rtl/ccm_capture_input.sv
// TimerA CCM capture input: source select, synchronizer, edge detect, TAR capture and flags.
// Optional CCM_INPUT_FILTER_EN adds a 2-sample stability filter after the synchronizer.
module ccm_capture_input #(
    parameter int unsigned TAR_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 TimerClock,
    input  logic                 reset,
    input  logic                 CCIA,
    input  logic                 CCIB,
    input  logic [1:0]           CCIS,
    input  logic [1:0]           CM,
    input  logic                 SCS,
    input  logic                 CAP,
    input  logic                 EQUn,
    input  logic [TAR_WIDTH-1:0] TAR,
    input  logic                 clrCCIFG,
    input  logic                 clrCOV,
    output logic                 CCI,
    output logic                 SCCI,
    output logic                 capWrite,
    output logic [TAR_WIDTH-1:0] capVal,
    output logic                 CCIFG,
    output logic                 COV
);

    localparam logic [1:0] CM_RISE = 2'd1;
    localparam logic [1:0] CM_FALL = 2'd2;
    localparam logic [1:0] CM_BOTH = 2'd3;

    logic                   sel_c;
    logic                   cci_c;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             ccis_q;
    logic                   prev_q, prev_d;
    logic                   primed_q, primed_d;
    logic                   pending_q, pending_d;
    logic                   capwrite_q, capwrite_d;
    logic [TAR_WIDTH-1:0]   capval_q, capval_d;
    logic                   ccifg_q, ccifg_d;
    logic                   cov_q, cov_d;
    logic                   scci_q, scci_d;
    logic                   rise_c, fall_c, edge_c, trig_c, cap_c, ifg_set_c, ccis_chg_c;

    // Capture source mux
    always_comb begin
        sel_c = 1'b0;
        case (CCIS)
            2'd0:    sel_c = CCIA;
            2'd1:    sel_c = CCIB;
            2'd2:    sel_c = 1'b0;
            default: sel_c = 1'b1;
        endcase
    end

    assign sync_d = {sync_q[SYNC_STAGES-2:0], sel_c};

`ifdef CCM_INPUT_FILTER_EN
    logic filt_hold_q;
    logic filt_cci_q;

    // CCI follows the synchronizer only once two consecutive samples agree
    always_ff @(posedge TimerClock) begin
        if (reset) begin
            filt_hold_q <= 1'b0;
            filt_cci_q  <= 1'b0;
        end else begin
            filt_hold_q <= sync_q[SYNC_STAGES-1];
            if (sync_q[SYNC_STAGES-1] == filt_hold_q) begin
                filt_cci_q <= filt_hold_q;
            end
        end
    end

    assign cci_c = filt_cci_q;
`else
    assign cci_c = sync_q[SYNC_STAGES-1];
`endif

    // Edge detection and capture trigger
    always_comb begin
        rise_c     = cci_c & ~prev_q;
        fall_c     = ~cci_c & prev_q;
        edge_c     = 1'b0;
        case (CM)
            CM_RISE: edge_c = rise_c;
            CM_FALL: edge_c = fall_c;
            CM_BOTH: edge_c = rise_c | fall_c;
            default: edge_c = 1'b0;
        endcase
        ccis_chg_c = (CCIS != ccis_q);
        trig_c     = edge_c & CAP & primed_q;
        // SCS=1 defers the capture by one count; a pending capture always completes
        cap_c      = (trig_c & ~SCS) | pending_q;
        ifg_set_c  = cap_c | (~CAP & EQUn);
    end

    // Next-state for capture, flags and SCCI
    always_comb begin
        prev_d     = cci_c;
        primed_d   = ~ccis_chg_c;
        pending_d  = trig_c & SCS;
        capwrite_d = cap_c;
        capval_d   = capval_q;
        ccifg_d    = ccifg_q;
        cov_d      = cov_q;
        scci_d     = scci_q;
        if (cap_c) begin
            capval_d = TAR;
        end
        if (ifg_set_c) begin
            ccifg_d = 1'b1;
        end else if (clrCCIFG) begin
            ccifg_d = 1'b0;
        end
        if (cap_c && ccifg_q) begin
            cov_d = 1'b1;
        end else if (clrCOV) begin
            cov_d = 1'b0;
        end
        if (EQUn) begin
            scci_d = cci_c;
        end
    end

    always_ff @(posedge TimerClock) begin
        ccis_q <= CCIS;
        if (reset) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            primed_q   <= 1'b0;
            pending_q  <= 1'b0;
            capwrite_q <= 1'b0;
            capval_q   <= '0;
            ccifg_q    <= 1'b0;
            cov_q      <= 1'b0;
            scci_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            pending_q  <= pending_d;
            capwrite_q <= capwrite_d;
            capval_q   <= capval_d;
            ccifg_q    <= ccifg_d;
            cov_q      <= cov_d;
            scci_q     <= scci_d;
        end
    end

    assign CCI      = cci_c;
    assign SCCI     = scci_q;
    assign capWrite = capwrite_q;
    assign capVal   = capval_q;
    assign CCIFG    = ccifg_q;
    assign COV      = cov_q;

endmodule

// File: tb/tb_ccm_capture_input.sv
// Bench for ccm_capture_input: directed scenarios plus random traffic, scored against an event-schedule model.
module tb_ccm_capture_input;

    localparam int unsigned TW   = 16;
    localparam int unsigned S    = 2;
    localparam int          NMAX = 4096;

    logic          clk = 1'b0;
    logic          reset, CCIA, CCIB, SCS, CAP, EQUn, clrCCIFG, clrCOV;
    logic [1:0]    CCIS, CM;
    logic [TW-1:0] TAR;
    logic          CCI, SCCI, capWrite, CCIFG, COV;
    logic [TW-1:0] capVal;

    always #5 clk = ~clk;

    ccm_capture_input #(.TAR_WIDTH(TW), .SYNC_STAGES(S)) dut (
        .TimerClock(clk), .reset(reset), .CCIA(CCIA), .CCIB(CCIB), .CCIS(CCIS), .CM(CM),
        .SCS(SCS), .CAP(CAP), .EQUn(EQUn), .TAR(TAR), .clrCCIFG(clrCCIFG), .clrCOV(clrCOV),
        .CCI(CCI), .SCCI(SCCI), .capWrite(capWrite), .capVal(capVal), .CCIFG(CCIFG), .COV(COV)
    );

    typedef struct packed {
        logic          capw;
        logic [TW-1:0] capval;
        logic          cci;
        logic          scci;
        logic          ifg;
        logic          cov;
    } stat_t;

    stat_t         stat_q[$];
    logic [TW-1:0] cap_q[$];
    int            errors = 0;
    int            checks = 0;
    int            dut_caps = 0;
    int            m_caps = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;

    // Model history: one entry per cycle
    bit       rst_h[NMAX];
    bit       mux_h[NMAX];
    bit       cci_h[NMAX];
    bit       src[NMAX];
    bit [1:0] ccis_h[NMAX];
    bit       m_ifg, m_cov, m_scci;
    bit [TW-1:0] m_capval;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronizer output at cycle t: the selected input S cycles earlier, zero inside a reset window
    function automatic bit raw_at(input int t);
        for (int k = 1; k <= int'(S); k++) begin
            if (t - k < 0 || rst_h[t-k]) return 1'b0;
        end
        return mux_h[t-int'(S)];
    endfunction

    function automatic bit cci_at(input int t);
`ifdef CCM_INPUT_FILTER_EN
        bit a, b;
        if (t < 2 || rst_h[t-1]) return 1'b0;
        a = raw_at(t-1);
        b = rst_h[t-2] ? 1'b0 : raw_at(t-2);
        return (a == b) ? a : cci_h[t-1];
`else
        return raw_at(t);
`endif
    endfunction

    task automatic model_eval();
        int t;
        bit mux, cci_t, prev_t, primed, rise, fall, edg, trig, cap;
        t = cyc;
        case (CCIS)
            2'd0:    mux = CCIA;
            2'd1:    mux = CCIB;
            2'd2:    mux = 1'b0;
            default: mux = 1'b1;
        endcase
        mux_h[t]  = mux;
        rst_h[t]  = reset;
        ccis_h[t] = CCIS;
        cci_t  = cci_h[t];
        prev_t = (t < 1 || rst_h[t-1]) ? 1'b0 : cci_h[t-1];
        primed = (t >= 2) && !rst_h[t-1] && (ccis_h[t-1] == ccis_h[t-2]);
        rise   = cci_t && !prev_t;
        fall   = !cci_t && prev_t;
        edg    = (CM == 2'd1 && rise) || (CM == 2'd2 && fall) || (CM == 2'd3 && (rise || fall));
        trig   = !reset && CAP && primed && edg;
        if (trig) begin
            if (SCS) src[t+1] = 1'b1;
            else     src[t]   = 1'b1;
        end
        cap = src[t] && !reset;
        if (reset) begin
            m_ifg = 0; m_cov = 0; m_scci = 0; m_capval = '0;
        end else begin
            if (cap && m_ifg) m_cov = 1'b1;
            else if (clrCOV)  m_cov = 1'b0;
            if (cap || (!CAP && EQUn)) m_ifg = 1'b1;
            else if (clrCCIFG)         m_ifg = 1'b0;
            if (EQUn) m_scci = cci_t;
            if (cap) begin
                m_capval = TAR;
                cap_q.push_back(TAR);
                m_caps++;
            end
        end
        cci_h[t+1] = cci_at(t+1);
        stat_q.push_back('{capw: cap, capval: m_capval, cci: cci_h[t+1], scci: m_scci, ifg: m_ifg, cov: m_cov});
    endtask

    task automatic step();
        if (cyc + 2 >= NMAX) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NMAX);
            $fatal(1, "cycle budget exhausted");
        end
        model_eval();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc++;
        TAR = TAR + 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    // Monitor: per-cycle status plus capture scoreboard on each capWrite
    always @(negedge clk) begin
        stat_t e;
        if (mon_en && stat_q.size() > 0) begin
            e = stat_q.pop_front();
            chk("capWrite", 32'(capWrite), 32'(e.capw));
            chk("capVal_hold", 32'(capVal), 32'(e.capval));
            chk("CCI", 32'(CCI), 32'(e.cci));
            chk("SCCI", 32'(SCCI), 32'(e.scci));
            chk("CCIFG", 32'(CCIFG), 32'(e.ifg));
            chk("COV", 32'(COV), 32'(e.cov));
            if (capWrite === 1'b1) begin
                dut_caps++;
                if (cap_q.size() == 0) chk("unexpected_capWrite", 32'(capWrite), 32'(0));
                else                   chk("capVal", 32'(capVal), 32'(cap_q.pop_front()));
            end
        end
    end

    initial begin
        int n0;
        reset = 1'b1; CCIA = 0; CCIB = 0; CCIS = 2'd0; CM = 2'd1; SCS = 0; CAP = 1;
        EQUn = 0; clrCCIFG = 0; clrCOV = 0; TAR = '0;

        // Rising capture, SCS=0
        do_reset(2);
        chk("reset_CCIFG", 32'(CCIFG), 32'(0));
        chk("reset_capVal", 32'(capVal), 32'(0));
        TAR = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            CCIA = (TAR >= 16'h0105);
            step();
        end
        chk("rise_capVal", 32'(capVal), 32'h0107);
        chk("rise_CCIFG", 32'(CCIFG), 32'(1));
        chk("rise_COV", 32'(COV), 32'(0));

        // Overflow, clears, set-over-clear
        CCIA = 0; repeat (3) step();
        CCIA = 1; repeat (4) step();
        chk("ovf_COV", 32'(COV), 32'(1));
        clrCOV = 1; clrCCIFG = 1; step();
        clrCOV = 0; clrCCIFG = 0;
        chk("clr_COV", 32'(COV), 32'(0));
        chk("clr_CCIFG", 32'(CCIFG), 32'(0));
        CCIA = 0; repeat (3) step();
        CCIA = 1; step(); step();
        clrCCIFG = 1; step();
        clrCCIFG = 0;
        chk("setclr_capWrite", 32'(capWrite), 32'(1));
        chk("setclr_CCIFG", 32'(CCIFG), 32'(1));
        chk("setclr_COV", 32'(COV), 32'(0));

        // Synchronous capture delay
        SCS = 1; CCIA = 0;
        do_reset(2);
        TAR = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            CCIA = (TAR >= 16'h0105);
            step();
        end
        chk("scs_capVal", 32'(capVal), 32'h0108);

        // Both edges on CCIB toggling every 4 cycles
        SCS = 0; CCIS = 2'd1; CM = 2'd3; CCIB = 0;
        do_reset(2);
        n0 = dut_caps;
        for (int k = 0; k < 32; k++) begin
            CCIB = ((k / 4) % 2) == 1;
            step();
        end
        repeat (4) step();
        chk("both_edge_count", 32'(dut_caps - n0), 32'(7));

        // Switch source to VCC while CCI=0
        CCIS = 2'd0; CM = 2'd1; CCIA = 0;
        do_reset(2);
        repeat (4) step();
        CCIS = 2'd3;
        repeat (6) step();

        // Compare mode and SCCI
        CCIS = 2'd0; CAP = 0; CCIA = 1;
        do_reset(2);
        n0 = dut_caps;
        repeat (5) step();
        chk("cmp_no_capture", 32'(dut_caps - n0), 32'(0));
        chk("cmp_SCCI_before", 32'(SCCI), 32'(0));
        EQUn = 1; step();
        EQUn = 0;
        chk("cmp_SCCI", 32'(SCCI), 32'(1));
        chk("cmp_CCIFG", 32'(CCIFG), 32'(1));

        // Reset with capture pending and both flags set
        CAP = 1; SCS = 1; CCIA = 0;
        do_reset(2);
        repeat (3) step();
        for (int r = 0; r < 2; r++) begin
            CCIA = 1; repeat (4) step();
            CCIA = 0; repeat (3) step();
        end
        chk("pre_reset_COV", 32'(COV), 32'(1));
        CCIA = 1; repeat (3) step();
        reset = 1; step();
        reset = 0;
        chk("rst_CCI", 32'(CCI), 32'(0));
        chk("rst_SCCI", 32'(SCCI), 32'(0));
        chk("rst_capWrite", 32'(capWrite), 32'(0));
        chk("rst_capVal", 32'(capVal), 32'(0));
        chk("rst_CCIFG", 32'(CCIFG), 32'(0));
        chk("rst_COV", 32'(COV), 32'(0));

        // Random traffic, including TAR wrap
        TAR = 16'hFFC0;
        for (int i = 0; i < 2000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 23) == 0) CCIS = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) CM   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) CAP  = ~CAP;
            if ($urandom_range(0, 11) == 0) SCS  = ~SCS;
            if ($urandom_range(0, 2) == 0)  CCIA = ~CCIA;
            if ($urandom_range(0, 4) == 0)  CCIB = ~CCIB;
            EQUn     = ($urandom_range(0, 7) == 0);
            clrCCIFG = ($urandom_range(0, 9) == 0);
            clrCOV   = ($urandom_range(0, 9) == 0);
            step();
        end
        reset = 0; EQUn = 0; clrCCIFG = 0; clrCOV = 0;
        repeat (4) step();
        @(negedge clk);
        #1;
        chk("cap_q_drained", 32'(cap_q.size()), 32'(0));
        chk("capture_total", 32'(dut_caps), 32'(m_caps));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccm_capture_input.md
Name: ccm_capture_input

Overview:
- Input side of a TimerA Capture/Compare channel, the counterpart of the CCM output logic.
- Selects the capture source (CCIS) and synchronizes it into the TimerClock domain, then detects the programmed edge (CM).
- On a detected edge, latches TAR and raises CCIFG, flagging capture overflow (COV).
- Provides the CCI/SCCI read-back bits of TAxCCTLn. Sits between the PIN module and the TAxCCRn/TAxCCTLn registers.

Parameters:
- TAR_WIDTH, 16, width of the timer count and capture register.
- SYNC_STAGES, 2, flip-flop stages on the selected input (legal 2..3).

Ports:
- TimerClock  input  1  timer clock from the TimerA base; the only clock.
- reset  input  1  synchronous, active-high reset.
- CCIA  input  1  capture input A (pin).
- CCIB  input  1  capture input B (internal source).
- CCIS  input  2  source select: 0=CCIA, 1=CCIB, 2=GND, 3=VCC.
- CM  input  2  capture mode: 0=none, 1=rising, 2=falling, 3=both.
- SCS  input  1  synchronous-capture select.
- CAP  input  1  1=capture mode, 0=compare mode.
- EQUn  input  1  compare-equal pulse from this channel.
- TAR  input  TAR_WIDTH  current timer count.
- clrCCIFG  input  1  one-cycle software clear of CCIFG.
- clrCOV  input  1  one-cycle software clear of COV.
- CCI  output  1  synchronized selected input (TAxCCTLn.CCI).
- SCCI  output  1  CCI latched on EQUn.
- capWrite  output  1  one-cycle strobe: write capVal into TAxCCRn.
- capVal  output  TAR_WIDTH  captured TAR value, held until the next capture.
- CCIFG  output  1  capture/compare interrupt flag (capture-set portion).
- COV  output  1  capture overflow flag.

Behaviour:
- Reset (synchronous, on a TimerClock edge with reset=1):
  - Clears the sync chain, prev-sample, primed, pending, CCI, SCCI, capWrite, capVal, CCIFG and COV.
  - reset has priority over every other input.
- Source mux: combinational on CCIS. GND and VCC are constant 0/1.
- Synchronizer: the muxed bit passes through SYNC_STAGES flops. CCI is the last stage, so an input change reaches CCI SYNC_STAGES cycles later.
- Edge detect:
  - prev <= CCI every cycle.
  - rise = CCI & ~prev; fall = ~CCI & prev.
  - edge = (CM==1 & rise) | (CM==2 & fall) | (CM==3 & (rise|fall)).
- Priming: the first cycle after reset, and the first cycle after any CCIS change, load prev without asserting edge. The primed flag is cleared by reset and by a CCIS change.
- Capture trigger: trig = edge & CAP & primed. Whenever CAP=0, no triggers occur, but prev still tracks.
- SCS=0: on the trig cycle, capVal <= TAR and capWrite=1 on the next cycle. Latency from the CCI edge to capWrite is 1 cycle.
- SCS=1:
  - trig sets pending.
  - On the following cycle, capVal <= TAR (one count later) and capWrite=1.
  - A new trig while pending is set starts a new capture, and the in-flight capture still completes.
  - A change of SCS mid-pending completes the pending capture.
- Flags:
  - CCIFG is set on every capture (same cycle as capWrite).
  - COV is set if a capture occurs while CCIFG=1.
  - clrCCIFG/clrCOV clear their flag; a set and a clear in the same cycle leave the flag set.
  - In compare mode (CAP=0), EQUn sets CCIFG with the same set-over-clear rule.
- SCCI: SCCI <= CCI on each cycle with EQUn=1, else hold. This applies regardless of CAP.
- Width: capVal is a straight copy of TAR. TAR wrap (0xFFFF->0x0000) needs no special handling.

Optional Feature:
- Macro CCM_INPUT_FILTER_EN.
- Defined: a 2-sample majority/stability filter follows the synchronizer. CCI changes only after the synchronized value has been stable for 2 consecutive cycles, so single-cycle glitches are rejected. Latency grows by 2 cycles.
- Undefined: CCI is the raw synchronizer output, with no filtering.

Test Plan:
- Rising capture: CCIS=0, CM=1, CAP=1, SCS=0, TAR counting from 0x0100; CCIA 0->1 at TAR=0x0105. Expect CCI high at 0x0107 (SYNC_STAGES=2), capWrite one cycle later, capVal=0x0107, CCIFG=1, COV=0.
- Overflow: a second rising edge with CCIFG still 1 sets COV=1. clrCOV and clrCCIFG then drop both. A simultaneous capture and clrCCIFG leaves CCIFG=1.
- SCS=1 delay: same stimulus as the rising-capture case. capWrite comes one cycle later and capVal=0x0108.
- Both edges / source switching:
  - CM=3, CCIB toggling every 4 cycles gives one capture per toggle.
  - Switching CCIS to VCC while CCI=0 gives no capture in the priming cycle. The 0->1 transition afterwards is captured only if it occurs after priming.
- Compare/SCCI: CAP=0 with CCIA=1 gives no capWrite. EQUn pulse gives SCCI=1 and CCIFG=1.
- Reset mid-operation: assert reset with SCS=1 pending and CCIFG=COV=1. All outputs are 0 on the next edge, with no capWrite. (With CCM_INPUT_FILTER_EN, a 1-cycle CCIA glitch produces no capture.)
